alu_pipe_seq: RTL and testbench
===============================

// Module: alu_pipe_seq
// PURPOSE
//  Parametrised, handshaked successor of the combinational ALU/flag-register pair. It registers
//  operands and result, and accepts one op per cycle with valid/ready on both sides.
//  Adds a multi-cycle shift-add multiplier and an arithmetic shift right that keeps the MSB.
//  Sits between the register-file read ports and the result bus in the datapath.
// PARAMETERS
//  WIDTH   16  full datapath width; must be even and >= 4; HW = WIDTH/2 is the half width
// PORTS
//  Clock     in   1      rising-edge clock
//  Reset     in   1      asynchronous, active-low reset
//  InValid   in   1      A, B, FunSel, WF are valid
//  InReady   out  1      block can accept an op this cycle
//  A         in   WIDTH  operand A
//  B         in   WIDTH  operand B
//  FunSel    in   5      [4]=1 full width, 0 half width; [3:0]=opcode
//  WF        in   1      commit flags for this op
//  OutValid  out  1      ALUOut holds a result
//  OutReady  in   1      consumer takes the result
//  ALUOut    out  WIDTH  result; bits above HW are 0 in half mode
//  FlagsOut  out  4      {Z,C,N,O} flag register
// BEHAVIOUR
//  - Reset (Reset=0, async): state IDLE; ALUOut=0, FlagsOut=0, OutValid=0; any in-flight MUL is discarded.
//  - Accept = InValid & InReady. At accept, capture A, B, FunSel, WF and the current FlagsOut[2] (Cin).
//    Inputs may change afterwards.
//  - Operating width n = FunSel[4] ? WIDTH : HW. Only the low n bits of A and B are used.
//  - Opcodes:
//    0 A, 1 B, 2 ~A, 3 ~B, 4 A+B, 5 A+B+Cin, 6 A-B, 7 A&B, 8 A|B, 9 A^B, A ~(A&B),
//    B LSL, C LSR, D ASR (MSB kept), E ROL through Cin, F MUL (low n bits of A*B).
//  - Flags are computed on the n-bit result:
//    - Z = (result==0); N = result[n-1] for all ops.
//    - ADD/ADC: C = carry out; O = operands share a sign and the result sign differs.
//    - SUB: C = 1 iff A>=B unsigned (no borrow); O = operand signs differ and the result sign differs from A.
//    - LSL/ROL: C = A[n-1]. LSR/ASR: C = A[0].
//    - MUL: C = O = (high n bits of the 2n-bit product != 0).
//    - Any flag not listed for an op keeps its old value.
//  - FSM, 3 states:
//    - IDLE: InReady=1. Accept of opcode!=F -> DONE. Accept of F -> BUSY with cnt=n.
//    - BUSY: InReady=0. One shift-add step per cycle, cnt-- each cycle. When cnt reaches 0 -> DONE.
//      MUL latency is therefore n+1 cycles from accept to OutValid.
//    - DONE: OutValid=1; ALUOut and the latched flags are held stable until OutReady.
//      InReady = OutReady.
//      - OutReady & accept of opcode!=F: stay DONE with the new result next cycle (back-to-back).
//      - OutReady & accept of F: -> BUSY.
//      - OutReady, no accept: -> IDLE, OutValid=0.
//  - Single-cycle ops: OutValid rises the cycle after accept (latency 1, throughput 1/cycle).
//  - Flag commit: FlagsOut updates on the same edge that loads ALUOut, only if the captured WF=1.
//    An op accepted in that same cycle uses the pre-update Cin.
//  - Reset asserted in BUSY or DONE: result dropped, no flag commit.
// TESTING (WIDTH=16)
//  1. Reset low mid-MUL (3 cycles in) -> OutValid=0, FlagsOut=0, InReady=1 one cycle after release.
//  2. FunSel=10100 A=7FFF B=0001 WF=1 -> ALUOut=8000, FlagsOut={0,0,1,1} one cycle after accept.
//  3. FunSel=00110 A=0003 B=0005 WF=1 -> ALUOut=00FE, C=0 (borrow), N=1, O=0.
//  4. FunSel=11111 A=0100 B=0100 -> OutValid exactly 17 cycles after accept; ALUOut=0000, Z=1, C=1, O=1.
//  5. ADD then ADC back-to-back with OutReady=1, A=FFFF B=0001 then A=B=0000 ->
//     ADC sees old Cin; ALUOut sequence 0000 then Cin_old.
//  6. OutReady=0 for 5 cycles with InValid=1 -> InReady=0, ALUOut/FlagsOut stable, no op lost or duplicated.
//     FunSel=11101 A=8002 -> ALUOut=C001, C=0.

Source files
------------

// File: rtl/alu_pipe_seq.sv
// Handshaked, registered ALU with {Z,C,N,O} flag register, full/half width modes
// and an n-step shift-add multiplier.
module alu_pipe_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FunSel,
  input  logic             WF,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             m_full;
  logic             m_wf;
  logic             accept;

  assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
  assign accept   = InValid && InReady;
  assign OutValid = (state == DONE);

  // Single-cycle ALU on masked operands; flags not owned by the op keep FlagsOut
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic [IW-1:0]    msb;
  logic [CW-1:0]    nb;
  logic             cin;
  logic             sa;
  logic             sb;
  logic             sr;
  logic [3:0]       flg;

  always_comb begin
    mask = FunSel[4] ? {WIDTH{1'b1}} : WIDTH'({HW{1'b1}});
    msb  = FunSel[4] ? IW'(WIDTH - 1) : IW'(HW - 1);
    nb   = FunSel[4] ? CW'(WIDTH) : CW'(HW);
    a_m  = A & mask;
    b_m  = B & mask;
    cin  = FlagsOut[2];
    sum  = {1'b0, a_m} + {1'b0, b_m} + W1'(cin && (FunSel[3:0] == 4'h5));
    sa   = a_m[msb];
    sb   = b_m[msb];
    res  = '0;
    flg  = FlagsOut;
    case (FunSel[3:0])
      4'h0: res = a_m;
      4'h1: res = b_m;
      4'h2: res = ~a_m;
      4'h3: res = ~b_m;
      4'h4, 4'h5: res = sum[WIDTH-1:0];
      4'h6: res = a_m - b_m;
      4'h7: res = a_m & b_m;
      4'h8: res = a_m | b_m;
      4'h9: res = a_m ^ b_m;
      4'hA: res = ~(a_m & b_m);
      4'hB: begin res = a_m << 1; flg[2] = sa; end
      4'hC: begin res = a_m >> 1; flg[2] = a_m[0]; end
      4'hD: begin
        res    = (a_m >> 1) | (sa ? (WIDTH'(1) << msb) : '0);
        flg[2] = a_m[0];
      end
      4'hE: begin res = (a_m << 1) | WIDTH'(cin); flg[2] = sa; end
      default: res = '0;
    endcase
    res = res & mask;
    sr  = res[msb];
    case (FunSel[3:0])
      4'h4, 4'h5: begin flg[2] = sum[nb]; flg[0] = (sa == sb) && (sr != sa); end
      4'h6:       begin flg[2] = (a_m >= b_m); flg[0] = (sa != sb) && (sr != sa); end
      default:    ;
    endcase
    flg[3] = (res == '0);
    flg[1] = sr;
  end

  // Multiplier step and final result/flags from the post-step product
  logic [WIDTH-1:0] m_mask;
  logic [IW-1:0]    m_msb;
  logic [CW-1:0]    m_nb;
  logic [PW-1:0]    prod_nx;
  logic [WIDTH-1:0] m_res;
  logic             m_hi;
  logic [3:0]       m_flg;

  always_comb begin
    m_mask  = m_full ? {WIDTH{1'b1}} : WIDTH'({HW{1'b1}});
    m_msb   = m_full ? IW'(WIDTH - 1) : IW'(HW - 1);
    m_nb    = m_full ? CW'(WIDTH) : CW'(HW);
    prod_nx = prod + (mplier[0] ? mcand : '0);
    m_res   = WIDTH'(prod_nx) & m_mask;
    m_hi    = |(prod_nx >> m_nb);
    m_flg   = {(m_res == '0), m_hi, m_res[m_msb], m_hi};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      ALUOut   <= '0;
      FlagsOut <= '0;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      m_full   <= 1'b0;
      m_wf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (FunSel[3:0] == 4'hF) begin
              state  <= BUSY;
              cnt    <= FunSel[4] ? CW'(WIDTH) : CW'(HW);
              prod   <= '0;
              mcand  <= PW'(a_m);
              mplier <= b_m;
              m_full <= FunSel[4];
              m_wf   <= WF;
            end else begin
              state  <= DONE;
              ALUOut <= res;
              if (WF) FlagsOut <= flg;
            end
          end else if (state == DONE && OutReady) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          prod   <= prod_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            ALUOut <= m_res;
            if (m_wf) FlagsOut <= m_flg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Directed bench for alu_pipe_seq (WIDTH=16): vector table plus handshake,
// multiplier latency, back-to-back, stall and reset sequences.
module tb_alu_pipe_seq;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [15:0] A;
  logic [15:0] B;
  logic [4:0]  FunSel;
  logic        WF;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] ALUOut;
  logic [3:0]  FlagsOut;

  int checks = 0;
  int errors = 0;

  alu_pipe_seq #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .FunSel(FunSel), .WF(WF), .OutValid(OutValid),
    .OutReady(OutReady), .ALUOut(ALUOut), .FlagsOut(FlagsOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  fs;
    logic [15:0] a;
    logic [15:0] b;
    logic        wf;
    logic [15:0] out;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one op and wait (bounded) for it to be accepted; returns #1 after the accept edge
  task automatic issue(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b,
                       input logic wf);
    int n = 0;
    FunSel = fs; A = a; B = b; WF = wf; InValid = 1'b1;
    while (!InReady && n < 50) begin
      @(posedge Clock); #1;
      n++;
    end
    if (!InReady) begin
      checks++; errors++;
      $display("FAIL issue_timeout: InReady stuck low for %0d cycles", n);
    end
    @(posedge Clock); #1;
    InValid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; FunSel = 5'b11111; WF = 1'b1;
  endtask

  task automatic mul_run(input string name, input logic [4:0] fs, input logic [15:0] a,
                         input logic [15:0] b, input int exp_lat, input logic [15:0] exp_out,
                         input logic [3:0] exp_flg);
    int lat = 1;
    issue(fs, a, b, 1'b1);
    chk({name, " busy_inready"}, 32'(InReady), 32'd0);
    while (!OutValid && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " out"}, 32'(ALUOut), 32'(exp_out));
    chk({name, " flags"}, 32'(FlagsOut), 32'(exp_flg));
    @(posedge Clock); #1;
    chk({name, " drained"}, 32'(OutValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // flags are {Z,C,N,O}; each row's expected flags follow from the previous row's
    vecs[0]  = '{5'b10100, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0011}; // ADD overflow
    vecs[1]  = '{5'b00110, 16'h0003, 16'h0005, 1'b1, 16'h00FE, 4'b0010}; // SUB half borrow
    vecs[2]  = '{5'b00100, 16'h12FF, 16'h0001, 1'b1, 16'h0000, 4'b1100}; // ADD half carry
    vecs[3]  = '{5'b10101, 16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000}; // ADC with Cin=1
    vecs[4]  = '{5'b10111, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 4'b0010}; // AND
    vecs[5]  = '{5'b01010, 16'hABFF, 16'h12FF, 1'b1, 16'h0000, 4'b1000}; // NAND half
    vecs[6]  = '{5'b10010, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b1000}; // NOT A, WF=0
    vecs[7]  = '{5'b11011, 16'h8001, 16'h0000, 1'b1, 16'h0002, 4'b0100}; // LSL
    vecs[8]  = '{5'b01110, 16'h0081, 16'h0000, 1'b1, 16'h0003, 4'b0100}; // ROL half, Cin=1
    vecs[9]  = '{5'b11100, 16'h0003, 16'h0000, 1'b1, 16'h0001, 4'b0100}; // LSR
    vecs[10] = '{5'b01101, 16'h0080, 16'h0000, 1'b1, 16'h00C0, 4'b0010}; // ASR half
    vecs[11] = '{5'b11001, 16'hAAAA, 16'h5555, 1'b1, 16'hFFFF, 4'b0010}; // XOR
    vecs[12] = '{5'b01000, 16'h1200, 16'h3400, 1'b1, 16'h0000, 4'b1000}; // OR half, masked
    vecs[13] = '{5'b10001, 16'h0000, 16'h1234, 1'b1, 16'h1234, 4'b0000}; // pass B
    vecs[14] = '{5'b10110, 16'h0005, 16'h0003, 1'b1, 16'h0002, 4'b0100}; // SUB no borrow
    vecs[15] = '{5'b10110, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0101}; // SUB overflow
    vecs[16] = '{5'b00011, 16'h0000, 16'h00F0, 1'b1, 16'h000F, 4'b0101}; // NOT B half

    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    A = '0; B = '0; FunSel = '0; WF = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset out", 32'(ALUOut), 32'h0);
    chk("reset flags", 32'(FlagsOut), 32'h0);
    chk("reset valid", 32'(OutValid), 32'd0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("post_reset inready", 32'(InReady), 32'd1);

    for (int i = 0; i < 17; i++) begin
      issue(vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].wf);
      chk($sformatf("vec%0d valid", i), 32'(OutValid), 32'd1);
      chk($sformatf("vec%0d out", i), 32'(ALUOut), 32'(vecs[i].out));
      chk($sformatf("vec%0d flags", i), 32'(FlagsOut), 32'(vecs[i].flg));
      @(posedge Clock); #1;
    end

    mul_run("mul_full_ovf", 5'b11111, 16'h0100, 16'h0100, 17, 16'h0000, 4'b1101);
    mul_run("mul_half", 5'b01111, 16'h12FF, 16'h0003, 9, 16'h00FD, 4'b0111);
    mul_run("mul_full", 5'b11111, 16'h0003, 16'h0005, 17, 16'h000F, 4'b0000);

    // Back-to-back ADD (no flag write) then ADC: ADC sees the unchanged C=0
    issue(5'b10100, 16'hFFFF, 16'h0001, 1'b0);
    chk("b2b_a add out", 32'(ALUOut), 32'h0000);
    chk("b2b_a add flags", 32'(FlagsOut), 32'h0);
    issue(5'b10101, 16'h0000, 16'h0000, 1'b1);
    chk("b2b_a adc valid", 32'(OutValid), 32'd1);
    chk("b2b_a adc out", 32'(ALUOut), 32'h0000);
    chk("b2b_a adc flags", 32'(FlagsOut), 32'b1000);
    @(posedge Clock); #1;
    chk("b2b_a drained", 32'(OutValid), 32'd0);

    // Back-to-back ADD with flag write: carry committed on the ADD's load edge feeds ADC
    issue(5'b10100, 16'hFFFF, 16'h0001, 1'b1);
    chk("b2b_b add out", 32'(ALUOut), 32'h0000);
    chk("b2b_b add flags", 32'(FlagsOut), 32'b1100);
    issue(5'b10101, 16'h0000, 16'h0000, 1'b1);
    chk("b2b_b adc out", 32'(ALUOut), 32'h0001);
    chk("b2b_b adc flags", 32'(FlagsOut), 32'b0000);
    @(posedge Clock); #1;

    // Consumer stalls with a second op waiting
    OutReady = 1'b0;
    issue(5'b11101, 16'h8002, 16'h0000, 1'b1);
    FunSel = 5'b10100; A = 16'h0001; B = 16'h0001; WF = 1'b1; InValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d inready", k), 32'(InReady), 32'd0);
      chk($sformatf("stall%0d valid", k), 32'(OutValid), 32'd1);
      chk($sformatf("stall%0d out", k), 32'(ALUOut), 32'hC001);
      chk($sformatf("stall%0d flags", k), 32'(FlagsOut), 32'b0010);
      @(posedge Clock); #1;
    end
    OutReady = 1'b1;
    #1;
    chk("stall release inready", 32'(InReady), 32'd1);
    @(posedge Clock); #1;
    InValid = 1'b0;
    chk("stall next valid", 32'(OutValid), 32'd1);
    chk("stall next out", 32'(ALUOut), 32'h0002);
    chk("stall next flags", 32'(FlagsOut), 32'b0000);
    @(posedge Clock); #1;
    chk("stall drained", 32'(OutValid), 32'd0);
    @(posedge Clock); #1;
    chk("stall no_dup valid", 32'(OutValid), 32'd0);
    chk("stall no_dup out", 32'(ALUOut), 32'h0002);

    // Reset three cycles into a multiply
    issue(5'b10010, 16'h0000, 16'h0000, 1'b1);
    chk("pre_reset flags", 32'(FlagsOut), 32'b0010);
    @(posedge Clock); #1;
    issue(5'b11111, 16'hFFFF, 16'hFFFF, 1'b1);
    repeat (2) begin
      @(posedge Clock); #1;
    end
    chk("mid_mul valid", 32'(OutValid), 32'd0);
    Reset = 1'b0;
    #1;
    chk("async reset valid", 32'(OutValid), 32'd0);
    chk("async reset flags", 32'(FlagsOut), 32'h0);
    chk("async reset out", 32'(ALUOut), 32'h0);
    #2;
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("after reset inready", 32'(InReady), 32'd1);
    chk("after reset valid", 32'(OutValid), 32'd0);
    chk("after reset flags", 32'(FlagsOut), 32'h0);
    repeat (20) begin
      @(posedge Clock); #1;
    end
    chk("mul discarded valid", 32'(OutValid), 32'd0);
    chk("mul discarded flags", 32'(FlagsOut), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
